// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative unsigned multiply/divide behind a valid/ready handshake
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       status
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLL = 4'b0011;
  localparam logic [3:0] OP_PASSA = 4'b0100, OP_XOR = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000, OP_SRA = 4'b1001, OP_MULU = 4'b1010, OP_DIVU = 4'b1011;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, nstate;
  logic [WIDTH-1:0] m, hi, lo, hi_n, lo_n, sum, diff, s_res, s_hi;
  logic [WIDTH:0] ms, t, d;
  logic [CW-1:0] cnt;
  logic [SHW-1:0] sh;
  logic [4:0] s_st;
  logic last, ovf, is_mul, is_div;
  assign sh = b[SHW-1:0];
  assign sum = a + b;
  assign diff = a - b;
  assign last = cnt == CW'(WIDTH - 1);
  assign is_mul = op == OP_MULU;
  assign is_div = op == OP_DIVU;
  assign in_ready = rst_n && state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    s_res = '0;
    s_hi = '0;
    ovf = 1'b0;
    case (op)
      OP_AND:   s_res = a & b;
      OP_OR:    s_res = a | b;
      OP_ADD: begin
        s_res = sum;
        ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OP_SLL:   s_res = a << sh;
      OP_PASSA: s_res = a;
      OP_XOR:   s_res = a ^ b;
      OP_SUB: begin
        s_res = diff;
        ovf = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
      end
      OP_SLT:   s_res = WIDTH'($signed(a) < $signed(b));
      OP_SRL:   s_res = a >> sh;
      OP_SRA:   s_res = WIDTH'($signed(a) >>> sh);
      // DIVU only completes here when the divisor is zero
      OP_DIVU: begin
        s_res = '1;
        s_hi = a;
      end
      default:  s_res = '0;
    endcase
    s_st = {op[3] & op[2], is_div, ovf, s_res == '0, s_res[WIDTH-1]};
  end
  // hi:lo is the shift-add accumulator in MUL and the remainder:quotient pair in DIV
  assign ms = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign t = {hi, lo[WIDTH-1]};
  assign d = t - {1'b0, m};
  assign hi_n = state == MUL ? ms[WIDTH:1] : d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
  assign lo_n = state == MUL ? {ms[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~d[WIDTH]};
  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (in_valid) nstate = is_mul ? MUL : (is_div && b != '0) ? DIV : DONE;
      MUL, DIV: if (last) nstate = DONE;
      DONE:     if (out_ready) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      result <= '0;
      result_hi <= '0;
      status <= '0;
    end else if (state == IDLE && in_valid) begin
      m <= is_mul ? a : b;
      hi <= '0;
      lo <= is_mul ? b : a;
      cnt <= '0;
      result <= s_res;
      result_hi <= s_hi;
      status <= s_st;
    end else if (state == MUL || state == DIV) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        result <= lo_n;
        result_hi <= hi_n;
        status <= {3'b000, lo_n == '0, lo_n[WIDTH-1]};
      end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized self-checking bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;
  localparam int W = 32;
  localparam logic [3:0] ADD = 4'h2, SUB = 4'h6, SLT = 4'h7, SRA = 4'h9, MULU = 4'hA, DIVU = 4'hB;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [3:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [W-1:0] result, result_hi;
  logic [4:0] status;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  alu_mdu #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi), .status(status)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] rh, output logic [4:0] st);
    longint sx, sy, s;
    int sh;
    logic [63:0] p;
    logic ov, dz, err;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    ov = 0; dz = 0; err = 0; rh = 0; r = 0;
    case (o)
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'h2: begin s = sx + sy; r = W'(s); ov = s > 64'sd2147483647 || s < -64'sd2147483648; end
      4'h3: r = W'(64'(x) << sh);
      4'h4: r = x;
      4'h5: r = x ^ y;
      4'h6: begin s = sx - sy; r = W'(s); ov = s > 64'sd2147483647 || s < -64'sd2147483648; end
      4'h7: r = sx < sy ? 1 : 0;
      4'h8: r = W'(64'(x) >> sh);
      4'h9: r = W'(sx >>> sh);
      4'hA: begin p = 64'(x) * 64'(y); r = p[31:0]; rh = p[63:32]; end
      4'hB: if (y == 0) begin r = '1; rh = x; dz = 1; end
            else begin r = x / y; rh = x % y; end
      default: err = 1;
    endcase
    st = {err, dz, ov, r == 0, r[W-1]};
  endfunction
  task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    logic [W-1:0] er, eh;
    logic [4:0] es;
    int n;
    bit busy_ok;
    model(o, x, y, er, eh, es);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1;
    check("ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0; op = 4'($urandom); a = $urandom; b = $urandom;
    n = 1;
    busy_ok = 1;
    while (!out_valid && n < 200) begin
      if (in_ready) busy_ok = 0;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, (o == MULU || (o == DIVU && y != 0)) ? 33 : 1);
    check("busy", busy_ok, 1);
    check("result", result, er);
    check("result_hi", result_hi, eh);
    check("status", status, es);
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1; op = 4'($urandom); a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("hold_result", result, er);
      check("hold_status", status, es);
      check("hold_hs", {out_valid, in_ready}, 2'b10);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    check("idle", {out_valid, in_ready}, 2'b01);
  endtask
  function automatic logic [W-1:0] pick();
    logic [W-1:0] sp [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    int k;
    k = $urandom_range(0, 7);
    return k < 5 ? sp[k] : k == 5 ? W'($urandom_range(0, 15)) : $urandom;
  endfunction
  initial begin
    bit quiet;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_result", {result, result_hi}, 0);
    check("rst_status", status, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_rst_ready", in_ready, 1);
    run(ADD, 32'h7FFFFFFF, 32'h1, 0);
    run(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run(DIVU, 100, 7, 0);
    run(DIVU, 5, 0, 0);
    run(SRA, 32'h80000000, 32'h24, 0);
    run(SLT, 32'h80000000, 32'h1, 0);
    run(SUB, 32'h80000000, 32'h1, 0);
    run(ADD, 32'h11, 32'h22, 5);
    run(4'hE, 32'h1234, 32'h5, 0);
    @(negedge clk);
    op = DIVU; a = 32'hDEADBEEF; b = 3; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_regs", {result, result_hi}, 0);
    check("abort_status", status, 0);
    check("abort_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("abort_ready_rel", in_ready, 1);
    quiet = 1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) quiet = 0;
    end
    check("abort_no_valid", quiet, 1);
    run(ADD, 2, 3, 0);
    repeat (300) run(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 2));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal values 8..64.
REQ-002 Parameter SHW, default 5: shift-amount width, taken from b[SHW-1:0], with SHW = clog2(WIDTH).
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 in_valid  input  1: operation request.
REQ-006 in_ready  output  1: block can accept a request.
REQ-007 op  input  4: operation code.
REQ-008 a, b  input  WIDTH each: operands.
REQ-009 out_valid  output  1: result available.
REQ-010 out_ready  input  1: consumer takes the result.
REQ-011 result  output  WIDTH: primary result; product low half or quotient for MULU/DIVU.
REQ-012 result_hi  output  WIDTH: product high half or remainder for MULU/DIVU; 0 for all other ops.
REQ-013 status  output  5: status[0]=neg, [1]=zero, [2]=ovf, [3]=dz, [4]=err.

Function
REQ-014 The op encoding SHALL be:
- 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 PASSA, 0101 XOR
- 0110 SUB, 0111 SLT (signed), 1000 SRL, 1001 SRA
- 1010 MULU (unsigned), 1011 DIVU (unsigned)
- 1100-1111 illegal
REQ-015 The FSM SHALL have states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-017 On acceptance of a single-cycle op (everything except MULU and DIVU), the registered result and status SHALL be loaded and the FSM SHALL enter DONE, so out_valid is 1 on the next cycle.
REQ-018 MULU SHALL be computed as unsigned shift-add, one bit per cycle, over exactly WIDTH cycles in MUL, then DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 DIVU SHALL be computed by restoring division, one bit per cycle, over exactly WIDTH cycles in DIV, then DONE.
REQ-020 DIVU with b==0 SHALL go directly to DONE in one cycle with result = all ones, result_hi = a, dz=1.
REQ-021 Operands SHALL be captured at acceptance; later changes on a, b or op SHALL NOT affect an operation in flight.
REQ-022 In DONE, out_valid=1 and result, result_hi and status SHALL be held stable until out_ready=1; on that edge the FSM enters IDLE. No new request is accepted in the same cycle.
REQ-023 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-024 ADD and SUB SHALL wrap modulo 2^WIDTH; ovf = signed overflow for ADD/SUB, 0 for all other ops.
REQ-025 SLT SHALL give 1 if signed a < signed b, else 0, and SHALL be correct even when a-b overflows.
REQ-026 Shifts SHALL use b[SHW-1:0] only: SLL/SRL fill with zeros, SRA fills with a[WIDTH-1]; a shift by 0 returns a.
REQ-027 Flag definitions:
- zero = (result == 0)
- neg = result[WIDTH-1]
- MULU/DIVU: result_hi is not included in either flag
REQ-028 An illegal op SHALL complete as a single-cycle op with result=0, result_hi=0, err=1, zero=1, and all other flags 0.
REQ-029 result, result_hi and status values outside DONE are don't-care for the consumer but SHALL NOT contain X.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, out_valid=0, result=0, result_hi=0, status=0, all internal iteration counters and partial results cleared.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-032 Reset asserted mid-MUL/DIV SHALL abort the operation; no out_valid pulse for it is ever produced.

Verification (WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, result=0x80000000, neg=1, ovf=1, zero=0.
REQ-034 MULU a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after acceptance, result_hi=0xFFFFFFFE, result=0x00000001, in_ready=0 throughout.
REQ-035 Two DIVU cases:
- a=100, b=7 -> result=14, result_hi=2, dz=0
- a=5, b=0 -> next cycle result=0xFFFFFFFF, result_hi=5, dz=1
REQ-036 SRA a=0x80000000, b=0x24 (shift 4) -> result=0xF8000000; SLT a=0x80000000, b=1 -> result=1, ovf=0.
REQ-037 Backpressure and illegal-op case:
- Hold out_ready=0 for 5 cycles with in_valid=1 and changing a/b/op: result stays stable, in_ready=0, nothing accepted.
- Then pulse out_ready: IDLE on the next cycle.
- op=1110: err=1, result=0.
REQ-038 Reset abort: assert rst_n=0 on cycle 10 of a DIVU, asynchronously between edges -> out_valid, result and status go to 0 immediately; after release, in_ready=1, and a fresh ADD 2+3 returns 5.
